// File: rtl/bus_slave_responder_if.sv
// as_n/wr_n/ack_n bus between a processor master and a wait-state slave.
// The master holds as_n low until it sees ack_n low; the slave holds ack_n low until as_n is released.
interface bus_slave_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              as_n;
    logic              wr_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              ack_n;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;

    modport master (
        output as_n, wr_n, addr, data_in,
        input  ack_n, data_out, data_oe
    );

    modport slave (
        input  as_n, wr_n, addr, data_in,
        output ack_n, data_out, data_oe
    );
endinterface

// File: rtl/bus_slave_responder.sv
// Register-memory bus slave: ack_n falls WAIT_CYC+1 edges after as_n is sampled low.
// ack_n stays low (master-paced) until as_n is sampled high; aborts in the wait phase drop the transfer.
module bus_slave_responder #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int WAIT_CYC = 2,
    parameter int TXC_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    bus_slave_responder_if.slave    bus,
    output logic                    in_idle,
    output logic [TXC_W-1:0]        tx_count,
    output logic [1:0]              slv_state
);
    localparam int         DEPTH   = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_wr;
    logic [DATA_W-1:0] lat_dat;
    logic              ack_q;
    logic              oe_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            lat_addr <= '0;
            lat_wr   <= 1'b0;
            lat_dat  <= '0;
            ack_q    <= 1'b1;
            oe_q     <= 1'b0;
            rd_q     <= '0;
            tx_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    // Bus inputs are captured only here; later changes are ignored.
                    if (!bus.as_n) begin
                        lat_addr <= bus.addr;
                        lat_wr   <= !bus.wr_n;
                        lat_dat  <= bus.data_in;
                        wait_cnt <= WAIT_LD;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.as_n) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state <= ST_ACK;
                        ack_q <= 1'b0;
                        oe_q  <= !lat_wr;
                        if (lat_wr) begin
                            mem[lat_addr] <= lat_dat;
                        end else begin
                            rd_q <= mem[lat_addr];
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ACK: begin
                    if (bus.as_n) begin
                        state    <= ST_IDLE;
                        ack_q    <= 1'b1;
                        oe_q     <= 1'b0;
                        tx_count <= tx_count + TXC_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ack_q <= 1'b1;
                    oe_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack_n    = ack_q;
    assign bus.data_oe  = oe_q;
    assign bus.data_out = rd_q;
    assign in_idle      = (state == ST_IDLE);
    assign slv_state    = state;
endmodule

// File: tb/tb_bus_slave_responder.sv
// Directed bench: main instance with WAIT_CYC=2 plus a WAIT_CYC=0 instance for minimum latency.
`timescale 1ns/1ps
module tb_bus_slave_responder;
    logic clk;
    logic reset_n;

    bus_slave_responder_if #(.DATA_W(32), .ADDR_W(4)) bus_a ();
    bus_slave_responder_if #(.DATA_W(32), .ADDR_W(4)) bus_b ();

    logic       in_idle_a, in_idle_b;
    logic [7:0] tx_count_a, tx_count_b;
    logic [1:0] state_a, state_b;

    bus_slave_responder #(.DATA_W(32), .ADDR_W(4), .WAIT_CYC(2), .TXC_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a),
        .in_idle(in_idle_a), .tx_count(tx_count_a), .slv_state(state_a)
    );

    bus_slave_responder #(.DATA_W(32), .ADDR_W(4), .WAIT_CYC(0), .TXC_W(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b),
        .in_idle(in_idle_b), .tx_count(tx_count_b), .slv_state(state_b)
    );

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transfer on bus_a; bus inputs are scrambled after the latch edge.
    task automatic xfer(input logic wr, input logic [3:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic oe);
        int n;
        bus_a.as_n    = 1'b0;
        bus_a.wr_n    = ~wr;
        bus_a.addr    = a;
        bus_a.data_in = d;
        tick();
        bus_a.wr_n    = wr;
        bus_a.addr    = ~a;
        bus_a.data_in = ~d;
        n = 0;
        while (bus_a.ack_n !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("ack_timeout", 64'(n), 64'(0));
        rd = bus_a.data_out;
        oe = bus_a.data_oe;
        bus_a.as_n = 1'b1;
        tick();
    endtask

    logic [31:0] rd;
    logic        oe;

    initial begin
        reset_n       = 1'b0;
        bus_a.as_n    = 1'b1;
        bus_a.wr_n    = 1'b1;
        bus_a.addr    = '0;
        bus_a.data_in = '0;
        bus_b.as_n    = 1'b1;
        bus_b.wr_n    = 1'b1;
        bus_b.addr    = '0;
        bus_b.data_in = '0;
        tick();
        tick();
        check("rst_ack_n", bus_a.ack_n, 1'b1);
        check("rst_data_oe", bus_a.data_oe, 1'b0);
        check("rst_data_out", bus_a.data_out, 32'h0);
        check("rst_in_idle", in_idle_a, 1'b1);
        check("rst_tx_count", tx_count_a, 8'd0);
        check("rst_state", state_a, 2'd0);
        reset_n = 1'b1;
        tick();

        // Write then read back one word.
        xfer(1'b1, 4'd3, 32'hA5A5_0001, rd, oe);
        check("wr_oe_low", oe, 1'b0);
        xfer(1'b0, 4'd3, 32'h0, rd, oe);
        check("rd_data", rd, 32'hA5A5_0001);
        check("rd_oe_high", oe, 1'b1);
        check("tx_after_2", tx_count_a, 8'd2);
        check("oe_after_release", bus_a.data_oe, 1'b0);
        check("data_out_holds", bus_a.data_out, 32'hA5A5_0001);

        // Exact latency: E0 latches, ack low only after E0+3.
        bus_a.as_n = 1'b0;
        bus_a.wr_n = 1'b1;
        bus_a.addr = 4'd3;
        tick();
        check("lat_e0_ack", bus_a.ack_n, 1'b1);
        check("lat_e0_state", state_a, 2'd1);
        tick();
        check("lat_e1_ack", bus_a.ack_n, 1'b1);
        tick();
        check("lat_e2_ack", bus_a.ack_n, 1'b1);
        tick();
        check("lat_e3_ack", bus_a.ack_n, 1'b0);
        check("lat_e3_state", state_a, 2'd2);
        tick();
        tick();
        check("lat_hold_ack", bus_a.ack_n, 1'b0);
        bus_a.as_n = 1'b1;
        tick();
        check("lat_release_ack", bus_a.ack_n, 1'b1);
        check("lat_release_idle", in_idle_a, 1'b1);
        check("tx_after_3", tx_count_a, 8'd3);

        // Abort during the wait phase.
        bus_a.as_n    = 1'b0;
        bus_a.wr_n    = 1'b0;
        bus_a.addr    = 4'd5;
        bus_a.data_in = 32'hDEAD_BEEF;
        tick();
        bus_a.as_n = 1'b1;
        tick();
        check("abort_idle", in_idle_a, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_ack", bus_a.ack_n, 1'b1);
        end
        check("abort_tx", tx_count_a, 8'd3);
        xfer(1'b0, 4'd5, 32'h0, rd, oe);
        check("abort_mem", rd, 32'h0);

        // Fill every word, then read them all back.
        for (int i = 0; i < 16; i++) xfer(1'b1, 4'(i), 32'(i * 3), rd, oe);
        for (int i = 0; i < 16; i++) begin
            xfer(1'b0, 4'(i), 32'h0, rd, oe);
            check($sformatf("fill_rd_%0d", i), rd, 64'(i * 3));
        end
        check("tx_after_fill", tx_count_a, 8'd36);

        // Asynchronous reset while a read is being acknowledged.
        bus_a.as_n = 1'b0;
        bus_a.wr_n = 1'b1;
        bus_a.addr = 4'd1;
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_oe", bus_a.data_oe, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ack", bus_a.ack_n, 1'b1);
        check("mid_rst_oe", bus_a.data_oe, 1'b0);
        check("mid_rst_state", state_a, 2'd0);
        check("mid_rst_tx", tx_count_a, 8'd0);
        bus_a.as_n = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        xfer(1'b0, 4'd1, 32'h0, rd, oe);
        check("post_rst_rd1", rd, 32'h0);
        xfer(1'b0, 4'd3, 32'h0, rd, oe);
        check("post_rst_rd3", rd, 32'h0);

        // Counter wrap: 256 completed transfers since reset.
        for (int i = 0; i < 253; i++) xfer(1'b1, 4'(i), 32'(i), rd, oe);
        check("tx_255", tx_count_a, 8'd255);
        xfer(1'b0, 4'd7, 32'h0, rd, oe);
        check("tx_wrap", tx_count_a, 8'd0);

        // Zero wait states: ack low right after E0+1.
        bus_b.as_n    = 1'b0;
        bus_b.wr_n    = 1'b0;
        bus_b.addr    = 4'd9;
        bus_b.data_in = 32'h1234_5678;
        tick();
        check("w0_e0_ack", bus_b.ack_n, 1'b1);
        tick();
        check("w0_e1_ack", bus_b.ack_n, 1'b0);
        bus_b.as_n = 1'b1;
        tick();
        check("w0_release", bus_b.ack_n, 1'b1);
        bus_b.as_n = 1'b0;
        bus_b.wr_n = 1'b1;
        tick();
        tick();
        check("w0_rd_ack", bus_b.ack_n, 1'b0);
        check("w0_rd_data", bus_b.data_out, 32'h1234_5678);
        bus_b.as_n = 1'b1;
        tick();
        check("w0_tx", tx_count_b, 8'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
